// File: rtl/pong_game_engine_pkg.sv
// Shared pong geometry, game limits and FSM state type.
// The renderer imports the same geometry so both sides agree on object sizes.
package pong_game_engine_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int BALL_SIZE    = 8;
    localparam int PADDLE_X     = 16;
    localparam int PADDLE_W     = 8;
    localparam int PADDLE_H     = 64;
    localparam int BALL_SPEED   = 2;
    localparam int PADDLE_SPEED = 4;
    localparam int MISS_PAUSE   = 60;

    // Counter limits are sized to their registers.
    localparam logic [1:0] LIVES     = 2'd3;
    localparam logic [3:0] MAX_SCORE = 4'd9;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        MISS      = 3'd3,
        GAME_OVER = 3'd4
    } pong_state_t;

endpackage

// File: rtl/pong_game_engine_if.sv
// Bundle between the game engine and its neighbours: buttons and frame tick in,
// object positions and game status out.
interface pong_game_engine_if;

    logic       frame_tick;
    logic       forward;
    logic       up_btn;
    logic       down_btn;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [9:0] paddle_y;
    logic [3:0] score;
    logic [1:0] lives;
    logic       game_over;
    logic [2:0] state_o;

    modport master (
        output frame_tick, forward, up_btn, down_btn,
        input  ball_x, ball_y, paddle_y, score, lives, game_over, state_o
    );

    modport slave (
        input  frame_tick, forward, up_btn, down_btn,
        output ball_x, ball_y, paddle_y, score, lives, game_over, state_o
    );

endinterface

// File: rtl/pong_game_engine_btn_sync.sv
// Two-flop synchroniser for a raw button. With EDGE set, the output is a
// one-cycle pulse on the synchronised rising edge; otherwise it is the level.
module btn_sync #(
    parameter bit EDGE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic sig_o
);

    logic meta_q;
    logic sync_q;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
        end
    end

    if (EDGE) begin : g_edge
        logic prev_q;

        // Remember the previous synchronised level for edge detection.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) prev_q <= 1'b0;
            else        prev_q <= sync_q;
        end

        assign sig_o = sync_q & ~prev_q;
    end else begin : g_level
        assign sig_o = sync_q;
    end

endmodule

// File: rtl/pong_game_engine.sv
// Frame-rate game-state engine for single-player pong. All state advances only in
// the frame_tick cycle, so the renderer sees positions that hold for a whole frame.
module pong_game_engine
    import pong_game_engine_pkg::*;
#(
    parameter int PAUSE_FRAMES = MISS_PAUSE
) (
    input  logic              clk,
    input  logic              rst_n,
    pong_game_engine_if.slave bus
);

    localparam int PW = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
    localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_FRAMES - 1);

    // Geometry in 11-bit signed so intermediate steps can go negative without wrapping.
    localparam logic signed [10:0] S_BALL_SPD = 11'(BALL_SPEED);
    localparam logic signed [10:0] S_PAD_SPD  = 11'(PADDLE_SPEED);
    localparam logic signed [10:0] S_PAD_MAX  = 11'(V_ACTIVE - PADDLE_H);
    localparam logic signed [10:0] S_BALL_YMX = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic signed [10:0] S_BALL_XMX = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic signed [10:0] S_PAD_EDGE = 11'(PADDLE_X + PADDLE_W);
    localparam logic signed [10:0] S_BALL_SZ  = 11'(BALL_SIZE);
    localparam logic signed [10:0] S_PAD_H    = 11'(PADDLE_H);
    localparam logic [9:0] BALL_X0   = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] BALL_Y0   = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] PADDLE_Y0 = 10'((V_ACTIVE - PADDLE_H) / 2);

    // Index 0 = forward (edge), 1 = up (level), 2 = down (level).
    logic [2:0] btn_raw;
    logic [2:0] btn_sig;
    assign btn_raw = {bus.down_btn, bus.up_btn, bus.forward};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        btn_sync #(.EDGE(gi == 0)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .btn_i (btn_raw[gi]),
            .sig_o (btn_sig[gi])
        );
    end

    pong_state_t   state_q;
    logic [9:0]    bx_q, by_q, py_q;
    logic          dx_pos_q, dy_pos_q, serve_pos_q;
    logic [3:0]    score_q;
    logic [1:0]    lives_q;
    logic [PW-1:0] pause_q;
    logic          pend_q;
    logic          game_over_q;

    logic signed [10:0] py_cur, bx_cur, by_cur;
    logic signed [10:0] py_d, bx_d, by_d;
    logic               dx_d, dy_d, hit_d, miss_d;
    logic [3:0]         score_d;

    assign py_cur  = $signed({1'b0, py_q});
    assign bx_cur  = $signed({1'b0, bx_q});
    assign by_cur  = $signed({1'b0, by_q});
    assign score_d = (score_q < MAX_SCORE) ? score_q + 4'd1 : score_q;

    // Candidate paddle and ball positions for this frame, including wall and paddle collisions.
    always_comb begin
        py_d = py_cur;
        if (btn_sig[1] && !btn_sig[2])      py_d = py_cur - S_PAD_SPD;
        else if (btn_sig[2] && !btn_sig[1]) py_d = py_cur + S_PAD_SPD;
        if (py_d < 11'sd0)          py_d = 11'sd0;
        else if (py_d > S_PAD_MAX)  py_d = S_PAD_MAX;

        dx_d   = dx_pos_q;
        dy_d   = dy_pos_q;
        hit_d  = 1'b0;
        miss_d = 1'b0;
        bx_d   = dx_pos_q ? bx_cur + S_BALL_SPD : bx_cur - S_BALL_SPD;
        by_d   = dy_pos_q ? by_cur + S_BALL_SPD : by_cur - S_BALL_SPD;

        if (by_d <= 11'sd0) begin
            by_d = 11'sd0;
            dy_d = 1'b1;
        end else if (by_d >= S_BALL_YMX) begin
            by_d = S_BALL_YMX;
            dy_d = 1'b0;
        end

        // Paddle overlap uses the paddle position from before this frame's move.
        if (dx_pos_q) begin
            if (bx_d >= S_BALL_XMX) begin
                bx_d = S_BALL_XMX;
                dx_d = 1'b0;
            end
        end else if (bx_d <= S_PAD_EDGE) begin
            if ((by_d + S_BALL_SZ > py_cur) && (by_d < py_cur + S_PAD_H)) begin
                hit_d = 1'b1;
                bx_d  = S_PAD_EDGE;
                dx_d  = 1'b1;
            end else if (bx_d <= 11'sd0) begin
                miss_d = 1'b1;
                bx_d   = 11'sd0;
            end
        end
    end

    // Game FSM with registered positions, counters and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bx_q        <= BALL_X0;
            by_q        <= BALL_Y0;
            py_q        <= PADDLE_Y0;
            dx_pos_q    <= 1'b1;
            dy_pos_q    <= 1'b1;
            serve_pos_q <= 1'b1;
            score_q     <= 4'd0;
            lives_q     <= LIVES;
            pause_q     <= '0;
            pend_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            if (btn_sig[0]) pend_q <= 1'b1;
            if (bus.frame_tick) begin
                if (state_q != GAME_OVER) py_q <= 10'(py_d);
                case (state_q)
                    IDLE: begin
                        if (pend_q) begin
                            state_q <= SERVE;
                            pend_q  <= 1'b0;
                        end
                    end
                    SERVE: begin
                        bx_q        <= BALL_X0;
                        by_q        <= BALL_Y0;
                        dx_pos_q    <= 1'b1;
                        dy_pos_q    <= serve_pos_q;
                        serve_pos_q <= ~serve_pos_q;
                        state_q     <= PLAY;
                    end
                    PLAY: begin
                        bx_q     <= 10'(bx_d);
                        by_q     <= 10'(by_d);
                        dx_pos_q <= dx_d;
                        dy_pos_q <= dy_d;
                        if (hit_d) begin
                            score_q <= score_d;
                            if (score_d == MAX_SCORE) begin
                                state_q     <= GAME_OVER;
                                game_over_q <= 1'b1;
                            end
                        end else if (miss_d) begin
                            lives_q <= lives_q - 2'd1;
                            pause_q <= '0;
                            state_q <= MISS;
                        end
                    end
                    MISS: begin
                        pend_q <= 1'b0;
                        if (pause_q == PAUSE_LAST) begin
                            pause_q <= '0;
                            if (lives_q == 2'd0) begin
                                state_q     <= GAME_OVER;
                                game_over_q <= 1'b1;
                            end else begin
                                state_q <= SERVE;
                            end
                        end else begin
                            pause_q <= pause_q + 1'b1;
                        end
                    end
                    GAME_OVER: begin
                        if (pend_q) begin
                            state_q     <= IDLE;
                            pend_q      <= 1'b0;
                            score_q     <= 4'd0;
                            lives_q     <= LIVES;
                            bx_q        <= BALL_X0;
                            by_q        <= BALL_Y0;
                            dx_pos_q    <= 1'b1;
                            game_over_q <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.ball_x    = bx_q;
    assign bus.ball_y    = by_q;
    assign bus.paddle_y  = py_q;
    assign bus.score     = score_q;
    assign bus.lives     = lives_q;
    assign bus.game_over = game_over_q;
    assign bus.state_o   = state_q;

endmodule
